// File: rtl/mod_mul_issue_pkg.sv
// Shared definitions for the streaming modular-multiply issuer: default widths,
// the Dilithium modulus and the issue FSM state encoding.
package mod_mul_issue_pkg;

  localparam int DEF_DATA_WIDTH = 48;
  localparam int DEF_Q_WIDTH    = 23;
  localparam int DEF_TAG_WIDTH  = 4;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_TIMEOUT    = 15;

  localparam logic [63:0] DILITHIUM_Q = 64'd8380417;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL   = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/mod_mul_issue_if.sv
// Bundle of the operand input stream, the reducer start/done channel, the result
// output stream and the sticky error flags of mod_mul_issue.
interface mod_mul_issue_if
  import mod_mul_issue_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int Q_WIDTH    = DEF_Q_WIDTH,
  parameter int TAG_WIDTH  = DEF_TAG_WIDTH
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [Q_WIDTH-1:0]    in_a;
  logic [Q_WIDTH-1:0]    in_b;
  logic [TAG_WIDTH-1:0]  in_tag;

  logic                  red_start;
  logic [DATA_WIDTH-1:0] red_data;
  logic                  red_done;
  logic [Q_WIDTH-1:0]    red_result;

  logic                  out_valid;
  logic                  out_ready;
  logic [Q_WIDTH-1:0]    out_data;
  logic [TAG_WIDTH-1:0]  out_tag;

  logic                  err_timeout;
  logic                  err_spurious;

  modport master (
    output in_valid, in_a, in_b, in_tag, red_done, red_result, out_ready,
    input  in_ready, red_start, red_data, out_valid, out_data, out_tag,
           err_timeout, err_spurious
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, red_done, red_result, out_ready,
    output in_ready, red_start, red_data, out_valid, out_data, out_tag,
           err_timeout, err_spurious
  );

endinterface

// File: rtl/mod_mul_issue_fifo.sv
// Synchronous FIFO with registered occupancy; full/empty depend only on state,
// so a pop in the same cycle never lifts full.
module mod_mul_issue_fifo #(
  parameter int WIDTH = 50,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mod_mul_issue.sv
// Streaming front end for a non-pipelined Barrett reducer: buffers operand pairs,
// registers a*b, runs one start/done transaction per pair and returns the residue.
module mod_mul_issue
  import mod_mul_issue_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int Q_WIDTH    = DEF_Q_WIDTH,
  parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input logic           clk,
  input logic           rst,
  mod_mul_issue_if.slave bus
);

  localparam int PW = 2 * Q_WIDTH;
  localparam int EW = PW + TAG_WIDTH;
  localparam int TW = $clog2(TIMEOUT + 1);

  if (PW > DATA_WIDTH) begin : g_width_chk
    $error("mod_mul_issue: 2*Q_WIDTH must not exceed DATA_WIDTH");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("mod_mul_issue: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (TIMEOUT < 8) begin : g_timeout_chk
    $error("mod_mul_issue: TIMEOUT must be >= 8");
  end

  state_t               state;
  state_t               state_nxt;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [EW-1:0]        fifo_rdata;

  logic [Q_WIDTH-1:0]   op_a_p0;
  logic [Q_WIDTH-1:0]   op_b_p0;
  logic [TAG_WIDTH-1:0] op_tag_p0;
  logic [PW-1:0]        prod_p1;
  logic                 start_q;
  logic [TW-1:0]        timer;
  logic                 timer_hit;
  logic                 out_valid_q;
  logic [Q_WIDTH-1:0]   out_data_q;
  logic [TAG_WIDTH-1:0] out_tag_q;
  logic                 err_timeout_q;
  logic                 err_spurious_q;

  mod_mul_issue_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.in_valid & ~fifo_full),
    .pop   (pop),
    .wdata ({bus.in_a, bus.in_b, bus.in_tag}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign timer_hit = (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = S_MUL;
        end
      end
      S_MUL:   state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        // A completion arriving on the timeout cycle still delivers its result
        if (bus.red_done)   state_nxt = S_HOLD;
        else if (timer_hit) state_nxt = S_IDLE;
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = S_MUL;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // p0: operand capture on pop / p1: product register feeding red_data
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_p0        <= '0;
      op_b_p0        <= '0;
      op_tag_p0      <= '0;
      prod_p1        <= '0;
      start_q        <= 1'b0;
      timer          <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_tag_q      <= '0;
      err_timeout_q  <= 1'b0;
      err_spurious_q <= 1'b0;
    end else begin
      if (pop) {op_a_p0, op_b_p0, op_tag_p0} <= fifo_rdata;
      unique case (state)
        S_MUL: begin
          prod_p1 <= PW'(op_a_p0) * PW'(op_b_p0);
          start_q <= 1'b1;
        end
        S_ISSUE: begin
          start_q <= 1'b0;
          timer   <= '0;
        end
        S_WAIT: begin
          if (bus.red_done) begin
            out_data_q  <= bus.red_result;
            out_tag_q   <= op_tag_p0;
            out_valid_q <= 1'b1;
          end else if (timer_hit) begin
            err_timeout_q <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_HOLD: begin
          if (bus.out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
      if (bus.red_done && state != S_WAIT) err_spurious_q <= 1'b1;
    end
  end

  assign bus.in_ready     = ~fifo_full;
  assign bus.red_start    = start_q;
  assign bus.red_data     = DATA_WIDTH'(prod_p1);
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_tag      = out_tag_q;
  assign bus.err_timeout  = err_timeout_q;
  assign bus.err_spurious = err_spurious_q;

endmodule

// File: tb/tb_mod_mul_issue.sv
// Directed bench for mod_mul_issue with a behavioural 6-cycle reducer and a
// result scoreboard queue.
module tb_mod_mul_issue;
  import mod_mul_issue_pkg::*;

  localparam int DW  = 48;
  localparam int QW  = 23;
  localparam int TGW = 4;

  typedef struct packed {
    logic [QW-1:0]  data;
    logic [TGW-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic stub;
  logic spur;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  mod_mul_issue_if #(.DATA_WIDTH(DW), .Q_WIDTH(QW), .TAG_WIDTH(TGW)) bus ();

  mod_mul_issue #(
    .DATA_WIDTH (DW),
    .Q_WIDTH    (QW),
    .TAG_WIDTH  (TGW),
    .FIFO_DEPTH (4),
    .TIMEOUT    (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reducer model: start sampled at edge S, done pulses high from edge S+5.
  logic          red_busy;
  logic [2:0]    red_cnt;
  logic [DW-1:0] red_cap;
  logic          done_r;
  logic [QW-1:0] res_r;

  always @(posedge clk) begin
    done_r <= 1'b0;
    if (rst) begin
      red_busy <= 1'b0;
      red_cnt  <= '0;
    end else if (red_busy) begin
      if (red_cnt == 3'd4) begin
        done_r   <= 1'b1;
        res_r    <= QW'(64'(red_cap) % DILITHIUM_Q);
        red_busy <= 1'b0;
      end else begin
        red_cnt <= red_cnt + 3'd1;
      end
    end else if (bus.red_start && !stub) begin
      red_busy <= 1'b1;
      red_cnt  <= '0;
      red_cap  <= bus.red_data;
    end
  end

  assign bus.red_done   = done_r | spur;
  assign bus.red_result = res_r;

  function automatic logic [QW-1:0] mulmod(input logic [QW-1:0] a, input logic [QW-1:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    return QW'(p % DILITHIUM_Q);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"},     64'(bus.in_ready), 1);
    chk({tag, "_out_valid"},    64'(bus.out_valid), 0);
    chk({tag, "_red_start"},    64'(bus.red_start), 0);
    chk({tag, "_red_data"},     64'(bus.red_data), 0);
    chk({tag, "_out_data"},     64'(bus.out_data), 0);
    chk({tag, "_out_tag"},      64'(bus.out_tag), 0);
    chk({tag, "_err_timeout"},  64'(bus.err_timeout), 0);
    chk({tag, "_err_spurious"}, 64'(bus.err_spurious), 0);
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input logic [QW-1:0] a, input logic [QW-1:0] b,
                      input logic [TGW-1:0] t, input logic [QW-1:0] exp,
                      input bit keep, output int hs);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = t;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("send_ready", 64'(bus.in_ready), 1);
      bus.in_valid = 1'b0;
      hs = cyc;
      return;
    end
    @(posedge clk);
    if (keep) sb_q.push_back('{data: exp, tag: t});
    @(negedge clk);
    hs = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, output int seen);
    int   n;
    exp_t e;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    seen = cyc;
    if (sb_q.size() == 0) begin
      chk({tag, "_unexpected_valid"}, 64'(bus.out_valid), 0);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_valid"}, 64'(bus.out_valid), 1);
    chk({tag, "_data"},  64'(bus.out_data), 64'(e.data));
    chk({tag, "_tag"},   64'(bus.out_tag), 64'(e.tag));
    if (bus.out_ready) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    int            hs;
    int            seen;
    int            prev;
    int            n;
    int            bad;
    int            starts;
    logic [QW-1:0] a;
    logic [QW-1:0] b;
    logic [QW-1:0] hd;
    logic [TGW-1:0] ht;

    rst           = 1'b1;
    stub          = 1'b0;
    spur          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // Small product, latency from handshake to out_valid
    send(23'd3, 23'd5, 4'd1, 23'd15, 1'b1, hs);
    wait_out("small", seen);
    chk("small_latency", 64'(seen - hs), 9);

    // (Q-1)^2 reduces to 1; reducer input held through WAIT
    send(23'd8380416, 23'd8380416, 4'd2, 23'd1, 1'b1, hs);
    n = 0;
    while (!bus.red_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("qm1_start", 64'(bus.red_start), 1);
    chk("qm1_red_data", 64'(bus.red_data), 64'h3FE0_0400_0000);
    repeat (4) @(negedge clk);
    chk("qm1_red_data_wait", 64'(bus.red_data), 64'h3FE0_0400_0000);
    chk("qm1_no_early_valid", 64'(bus.out_valid), 0);
    wait_out("qm1", seen);

    // Five back-to-back pairs: one is popped, four fill the buffer
    for (int i = 0; i < 5; i++) begin
      a = QW'(1000 + i * 123457);
      b = QW'(8000000 - i * 777777);
      send(a, b, TGW'(i), mulmod(a, b), 1'b1, hs);
      if (i == 3) chk("b2b_ready_after4", 64'(bus.in_ready), 1);
      if (i == 4) chk("b2b_full_after5", 64'(bus.in_ready), 0);
    end
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_out($sformatf("b2b%0d", i), seen);
      if (i > 0) chk($sformatf("b2b_spacing%0d", i), 64'(seen - prev), 9);
      prev = seen;
    end

    // Consumer stalls for 20 cycles in HOLD
    bus.out_ready = 1'b0;
    send(23'd123456, 23'd654321, 4'd9, mulmod(23'd123456, 23'd654321), 1'b1, hs);
    send(23'd42, 23'd8380000, 4'd10, mulmod(23'd42, 23'd8380000), 1'b1, hs);
    n = 0;
    while (!bus.out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    hd = bus.out_data;
    ht = bus.out_tag;
    bad = 0;
    starts = 0;
    repeat (20) begin
      @(negedge clk);
      if (!bus.out_valid || bus.out_data !== hd || bus.out_tag !== ht) bad++;
      if (bus.red_start) starts++;
    end
    chk("hold_stable", 64'(bad), 0);
    chk("hold_no_restart", 64'(starts), 0);
    chk("hold_data", 64'(hd), 64'(mulmod(23'd123456, 23'd654321)));
    bus.out_ready = 1'b1;
    wait_out("hold_a", seen);
    wait_out("hold_b", seen);

    // Reducer that never answers: timeout after 15 WAIT cycles, then recovery
    stub = 1'b1;
    send(23'd11, 23'd13, 4'd3, 23'd0, 1'b0, hs);
    while (cyc < hs + 17) @(negedge clk);
    chk("tmo_not_yet", 64'(bus.err_timeout), 0);
    @(negedge clk);
    chk("tmo_flag", 64'(bus.err_timeout), 1);
    chk("tmo_no_valid", 64'(bus.out_valid), 0);
    stub = 1'b0;
    @(negedge clk);
    send(23'd11, 23'd13, 4'd3, 23'd143, 1'b1, hs);
    wait_out("tmo_next", seen);
    chk("tmo_sticky", 64'(bus.err_timeout), 1);
    chk("spur_clear", 64'(bus.err_spurious), 0);

    // Stray completion while idle
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    chk("spur_flag", 64'(bus.err_spurious), 1);
    chk("spur_no_valid", 64'(bus.out_valid), 0);

    // Reset while waiting on the reducer with another pair buffered
    send(23'd100, 23'd200, 4'd5, 23'd0, 1'b0, hs);
    send(23'd300, 23'd400, 4'd6, 23'd0, 1'b0, hs);
    n = 0;
    while (!bus.red_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("midrst");
    rst = 1'b0;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.out_valid || bus.red_start) bad++;
    end
    chk("midrst_quiet", 64'(bad), 0);
    send(23'd4, 23'd6, 4'd7, 23'd24, 1'b1, hs);
    wait_out("midrst_after", seen);
    chk("scoreboard_empty", 64'(sb_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
